prog_cntr_stack: RTL and testbench
==================================

Name: prog_cntr_stack

Overview:
- Parametrised next-generation program counter with an integrated return-address stack.
- Holds the current instruction address and supports load (absolute jump), increment, signed relative branch, subroutine call and subroutine return.
- Sits between the instruction-fetch address bus and the control decoder.
- Flags stack full/empty and latches a sticky error on stack misuse.

Parameters:
- WIDTH, 8: address/counter width in bits.
- DEPTH, 4: return-stack entries (>=1).
- STEP, 1: increment applied on count and used for the return address.
- RESET_VAL, 0: value of Y after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- CountEn  in  1  advance Y by STEP.
- Load  in  1  absolute jump: Y <= A.
- Branch  in  1  relative jump: Y <= Y + Offset.
- Call  in  1  push Y+STEP, then Y <= A.
- Ret  in  1  pop top of stack into Y.
- A  in  WIDTH  jump/call target.
- Offset  in  WIDTH  two's-complement branch displacement.
- Y  out  WIDTH  current program counter (registered).
- Level  out  $clog2(DEPTH+1)  number of valid stack entries.
- Full  out  1  Level == DEPTH.
- Empty  out  1  Level == 0.
- Err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- One clock, synchronous active-high reset. All state updates on the rising edge of Clk.
- Reset: Y=RESET_VAL, Level=0, Empty=1, Full=0, Err=0. Stack contents don't-care.
- Reset mid-operation discards all stack entries.
- Single-cycle latency: the operation selected in cycle n is visible on Y in cycle n+1.
- Priority, highest first: Reset > Load > Call > Ret > Branch > CountEn > hold. Only the winning operation takes effect; lower-priority requests in the same cycle are ignored entirely.
- Load: Y <= A. Stack untouched.
- Call, not Full:
  - stack[Level] <= (Y+STEP) mod 2^WIDTH; Level+1; Y <= A.
- Call, Full:
  - no push, Y holds, Level holds, Err <= 1.
- Ret, not Empty:
  - Y <= stack[Level-1]; Level-1.
- Ret, Empty:
  - Y holds, Err <= 1.
- Branch: Y <= (Y + Offset) mod 2^WIDTH. Offset is treated as signed, and the result wraps both ways.
- CountEn: Y <= (Y + STEP) mod 2^WIDTH. 2^WIDTH-1 wraps to STEP-1.
- No request asserted: Y and stack hold.
- Full, Empty and Level are registered and consistent with the stack state in the same cycle.
- Err clears only on Reset. A successful Call or Ret does not clear it.
- Stack is LIFO only. No simultaneous push and pop, because priority guarantees one operation per cycle.

Test Plan (WIDTH=8, DEPTH=4, STEP=1, RESET_VAL=0):
1. Reset and count:
   - Reset=1 for 1 cycle -> Y=0, Empty=1, Level=0, Err=0.
   - CountEn=1 for 5 cycles -> Y=5.
   - CountEn=0 for 3 cycles -> Y stays 5.
2. Load and wrap:
   - Load=1, A=250 for 1 cycle -> Y=250.
   - CountEn=1 for 8 cycles -> 251..255, 0, 1, 2. Y=2.
3. Call/return:
   - Y=0x10; Call with A=0x40 -> Y=0x40, Level=1.
   - Count 2 cycles -> Y=0x42.
   - Ret -> Y=0x11, Level=0, Empty=1, Err=0.
4. Overflow and underflow:
   - From Y=0, Call A=0x20, 0x30, 0x40, 0x50 -> Full=1, Level=4, Y=0x50.
   - 5th Call A=0x60 -> Y=0x50, Level=4, Err=1.
   - 4 Rets -> Y=0x41, 0x31, 0x21, 0x01; Empty=1.
   - 5th Ret -> Y=0x01, Err still 1.
5. Branch:
   - Y=0x05, Branch with Offset=0xFA (-6) -> Y=0xFF.
   - Offset=0x03 -> Y=0x02.
   - Offset=0x00 -> Y=0x02.
6. Priority and reset:
   - Load=1, Call=1, CountEn=1, A=0x80 in the same cycle -> Y=0x80, Level unchanged.
   - With Level=3 and Err=1, assert Reset with Call=1 -> Y=0, Level=0, Empty=1, Err=0.

Source files
------------

// File: rtl/prog_cntr_stack_if.sv
// rtl/prog_cntr_stack_if.sv - request/status bundle between the fetch controller and the program counter
interface prog_cntr_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             CountEn;
    logic             Load;
    logic             Branch;
    logic             Call;
    logic             Ret;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Offset;
    logic [WIDTH-1:0] Y;
    logic [LW-1:0]    Level;
    logic             Full;
    logic             Empty;
    logic             Err;

    modport master (
        output CountEn, Load, Branch, Call, Ret, A, Offset,
        input  Y, Level, Full, Empty, Err
    );

    modport slave (
        input  CountEn, Load, Branch, Call, Ret, A, Offset,
        output Y, Level, Full, Empty, Err
    );
endinterface

// File: rtl/prog_cntr_stack.sv
// rtl/prog_cntr_stack.sv - program counter with integrated return-address stack
module prog_cntr_stack #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int STEP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    prog_cntr_stack_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] y_q, y_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [LW-1:0]    level_m1;

    // Pick the single winning request by fixed priority and compute next state
    always_comb begin
        y_d      = y_q;
        level_d  = level_q;
        err_d    = err_q;
        stack_d  = stack_q;
        level_m1 = level_q - LW'(1);

        if (bus.Load) begin
            y_d = bus.A;
        end else if (bus.Call) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                stack_d[level_q[IW-1:0]] = y_q + WIDTH'(STEP);
                level_d = level_q + LW'(1);
                y_d     = bus.A;
            end
        end else if (bus.Ret) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                y_d     = stack_q[level_m1[IW-1:0]];
                level_d = level_m1;
            end
        end else if (bus.Branch) begin
            // Two's-complement add wraps naturally in both directions
            y_d = y_q + bus.Offset;
        end else if (bus.CountEn) begin
            y_d = y_q + WIDTH'(STEP);
        end

        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // State registers; stack contents are left alone on reset since Level invalidates them
    always_ff @(posedge Clk) begin
        if (Reset) begin
            y_q     <= WIDTH'(RESET_VAL);
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
        stack_q <= stack_d;
    end

    assign bus.Y     = y_q;
    assign bus.Level = level_q;
    assign bus.Full  = full_q;
    assign bus.Empty = empty_q;
    assign bus.Err   = err_q;
endmodule

// File: tb/tb_prog_cntr_stack.sv
// tb/tb_prog_cntr_stack.sv - directed vector bench for prog_cntr_stack
module tb_prog_cntr_stack;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    prog_cntr_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

    prog_cntr_stack #(
        .WIDTH(8), .DEPTH(4), .STEP(1), .RESET_VAL(0)
    ) dut (
        .Clk  (clk),
        .Reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       rst;
        logic       cnt;
        logic       ld;
        logic       br;
        logic       cl;
        logic       rt;
        logic [7:0] a;
        logic [7:0] off;
        logic [7:0] y;
        logic [2:0] lvl;
        logic       full;
        logic       empty;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, cnt, ld, br, cl, rt, input logic [7:0] a, off,
                       input logic [7:0] y, input logic [2:0] lvl, input logic full, empty, err);
        vec_t v;
        v.rst = rst; v.cnt = cnt; v.ld = ld; v.br = br; v.cl = cl; v.rt = rt;
        v.a = a; v.off = off; v.y = y; v.lvl = lvl; v.full = full; v.empty = empty; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, cnt, ld, br, cl, rt, input logic [7:0] a, off);
        reset = rst; bus.CountEn = cnt; bus.Load = ld; bus.Branch = br;
        bus.Call = cl; bus.Ret = rt; bus.A = a; bus.Offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [7:0] y,
                             input logic [2:0] lvl, input logic full, empty, err);
        chk({tag, "_y"},     idx, bus.Y, y);
        chk({tag, "_level"}, idx, 8'(bus.Level), 8'(lvl));
        chk({tag, "_full"},  idx, 8'(bus.Full), 8'(full));
        chk({tag, "_empty"}, idx, 8'(bus.Empty), 8'(empty));
        chk({tag, "_err"},   idx, 8'(bus.Err), 8'(err));
    endtask

    initial begin
        //   rst cnt ld br cl rt  a      off    y      lvl full empty err
        add(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'(i), 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)  add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h05, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 8'd250, 8'h00, 8'd250, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'(250 + i), 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h42, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h30, 8'h00, 8'h30, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h40, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h50, 8'h00, 8'h50, 4, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h60, 8'h00, 8'h50, 4, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h41, 3, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h31, 2, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00, 8'hFA, 8'hFF, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00, 8'h03, 8'h02, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h02, 0, 0, 1, 1);
        add(0, 1, 1, 0, 1, 0, 8'h80, 8'h00, 8'h80, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 8'h00, 8'h05, 8'h80, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 1, 8'h70, 8'h00, 8'h70, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 1, 8'h00, 8'h10, 8'h81, 0, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cnt, vecs[i].ld, vecs[i].br, vecs[i].cl, vecs[i].rt,
                  vecs[i].a, vecs[i].off);
            check_all("vec", i, vecs[i].y, vecs[i].lvl, vecs[i].full, vecs[i].empty, vecs[i].err);
        end

        // Reset while three entries are live and Err is set, with a Call pending
        drive(0, 0, 0, 0, 1, 0, 8'h11, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h22, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h33, 8'h00);
        check_all("pre_reset", 0, 8'h33, 3, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 8'h44, 8'h00);
        check_all("reset_call", 0, 8'h00, 0, 0, 1, 0);

        // Return address pushed from 0xFF wraps to 0x00
        drive(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h10, 8'h00);
        check_all("wrap_call", 0, 8'h10, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        check_all("wrap_ret", 0, 8'h00, 0, 0, 1, 0);

        // Underflow straight out of reset sets the sticky flag, which a good call keeps
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        check_all("underflow", 0, 8'h00, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0, 8'h55, 8'h00);
        check_all("sticky", 0, 8'h55, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
